// File: rtl/moving_average_filter.sv
// Streaming moving-average filter over a run-time selectable power-of-two window,
// with valid/ready handshakes on both sides and optional signed/rounded arithmetic.
module moving_average_filter #(
   parameter int DATA_W     = 8,
   parameter int MAX_LOG2   = 4,
   parameter int RESET_LOG2 = 3,
   parameter int SIGNED     = 0,
   parameter int ROUND      = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clear,
   input  logic [$clog2(MAX_LOG2+1)-1:0]   win_log2,
   input  logic [DATA_W-1:0]               in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DATA_W-1:0]               out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            window_full,
   output logic [$clog2(MAX_LOG2+1)-1:0]   win_active,
   output logic [1:0]                      dbg_state
);

   localparam int WL_W   = $clog2(MAX_LOG2 + 1);
   localparam int D      = 1 << MAX_LOG2;
   localparam int SUM_W  = DATA_W + MAX_LOG2;
   localparam int FILL_W = MAX_LOG2 + 1;

   // Handshake rule: a transfer happens on a rising edge where valid and ready
   // are both 1; valid, once raised, holds its data until that edge.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   x_reg;
   logic [SUM_W-1:0]    oldest_reg;
   logic [SUM_W-1:0]    sum;
   logic [SUM_W-1:0]    sum_nxt;
   logic [SUM_W-1:0]    rnd;
   logic [SUM_W-1:0]    rounded;
   logic [DATA_W-1:0]   avg;
   logic [FILL_W-1:0]   fill;
   logic [FILL_W-1:0]   n_val;
   logic [MAX_LOG2-1:0] wr_ptr;
   logic [MAX_LOG2-1:0] rd_idx;
   logic [WL_W-1:0]     win_clamped;
   logic                accept;
   logic [DATA_W-1:0]   mem [D];

   function automatic logic [SUM_W-1:0] ext(input logic [DATA_W-1:0] v);
      ext = {{MAX_LOG2{(SIGNED != 0) && v[DATA_W-1]}}, v};
   endfunction

   assign n_val       = FILL_W'(1) << win_active;
   assign window_full = (fill == n_val);
   // N is a power of two no larger than D, so its low bits give (wr_ptr - N) mod D.
   assign rd_idx      = wr_ptr - n_val[MAX_LOG2-1:0];
   assign win_clamped = (win_log2 > WL_W'(MAX_LOG2)) ? WL_W'(MAX_LOG2) : win_log2;
   assign in_ready    = (state == IDLE) && !clear && (!out_valid || out_ready);
   assign accept      = in_valid && in_ready;
   assign dbg_state   = state;
   assign sum_nxt     = sum + ext(x_reg) - oldest_reg;
   assign rounded     = sum_nxt + rnd;

   always_comb begin
      rnd = '0;
      if ((ROUND != 0) && (win_active != '0))
         rnd = SUM_W'(1) << (win_active - WL_W'(1));
   end

   always_comb begin
      avg = '0;
      if (SIGNED != 0)
         avg = DATA_W'($signed(rounded) >>> win_active);
      else
         avg = DATA_W'(rounded >> win_active);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = FETCH;
         FETCH:   state_nxt = UPDATE;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         x_reg      <= '0;
         oldest_reg <= '0;
         sum        <= '0;
         fill       <= '0;
         wr_ptr     <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         win_active <= WL_W'(RESET_LOG2);
      end else if (clear) begin
         // Flush drops any sample in flight and adopts the new window.
         state      <= IDLE;
         sum        <= '0;
         fill       <= '0;
         wr_ptr     <= '0;
         out_valid  <= 1'b0;
         win_active <= win_clamped;
      end else begin
         state <= state_nxt;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept)
            x_reg <= in_data;
         if (state == FETCH)
            oldest_reg <= window_full ? ext(mem[rd_idx]) : '0;
         if (state == UPDATE) begin
            sum       <= sum_nxt;
            wr_ptr    <= wr_ptr + MAX_LOG2'(1);
            if (!window_full)
               fill <= fill + FILL_W'(1);
            out_data  <= avg;
            out_valid <= 1'b1;
         end
      end
   end

   // Sample storage is never reset; unwritten slots are masked by fill.
   always_ff @(posedge clk) begin
      if (!clear && (state == UPDATE))
         mem[wr_ptr] <= x_reg;
   end

endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Parametrised streaming moving-average filter over a power-of-two window. It replaces the fixed 8-bit, 8-tap strobe-driven averager. The window is selectable at run time, arithmetic can be signed or unsigned, rounding is optional, and both input and output use valid/ready handshakes. It sits between a sample source (ADC front end or pin capture) and a downstream consumer that may stall.

## Interface
- DATA_W, default 8: sample and output width.
- MAX_LOG2, default 4: log2 of the maximum window. Buffer depth D = 2^MAX_LOG2.
- RESET_LOG2, default 3: window log2 in effect after reset. Must be ≤ MAX_LOG2.
- SIGNED, default 0: 1 = two's-complement samples, sign extension and arithmetic shift. 0 = unsigned.
- ROUND, default 0: 1 = round half up, adding 2^(k-1) before the shift when k>0. 0 = truncate.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous flush; latches win_log2.
- win_log2  in  $clog2(MAX_LOG2+1)  requested window log2. Sampled only while clear=1. Values > MAX_LOG2 clamp to MAX_LOG2.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  filter accepts a sample this cycle.
- out_data  out  DATA_W  averaged value.
- out_valid  out  1  out_data valid; held until accepted.
- out_ready  in  1  consumer accepts out_data.
- window_full  out  1  N samples accumulated since the last reset or clear.
- win_active  out  $clog2(MAX_LOG2+1)  window log2 currently in effect (k). N = 2^k.

## Operation
- Storage: circular buffer of D words, DATA_W each.
  - wr_ptr has MAX_LOG2 bits and wraps modulo D.
  - fill counter saturates at N.
  - Running sum is SUM_W = DATA_W + MAX_LOG2 bits, signed when SIGNED=1. It cannot overflow.
- Buffer contents are never reset. Reads for slots not yet written are masked by fill.
- FSM states: IDLE, FETCH, UPDATE.
- IDLE
  - in_ready = !clear && (!out_valid || out_ready).
  - When in_valid && in_ready: register the sample into x_reg and go to FETCH.
- FETCH
  - oldest_reg <= (fill == N) ? buf[(wr_ptr - N) mod D] : 0, extended to SUM_W.
  - Go to UPDATE.
- UPDATE
  - sum <= sum + ext(x_reg) - oldest_reg.
  - buf[wr_ptr] <= x_reg.
  - wr_ptr++ (wraps).
  - fill <= min(fill+1, N).
  - out_data <= (new_sum + rnd) >>> k, low DATA_W bits, where rnd = ROUND && k>0 ? 2^(k-1) : 0.
  - out_valid <= 1. Go to IDLE.
- Warm-up: until window_full, the divisor is still N. The output ramps as if zeros were pre-loaded.
- k = 0: out_data equals the sample, delayed.
- out_valid clears on the edge where out_valid && out_ready. A same-edge new result re-sets it, with the UPDATE write taking priority.
- clear, sampled synchronously, takes priority over everything, including FETCH/UPDATE in flight. On that edge:
  - state <= IDLE
  - sum, fill, wr_ptr <= 0
  - out_valid <= 0
  - win_active <= clamp(win_log2)
  - The in-flight sample is discarded with no output.
- Run-time window change happens only through clear.

## Timing
- Reset values:
  - state IDLE; sum, fill, wr_ptr = 0.
  - out_data = 0, out_valid = 0, window_full = 0, win_active = RESET_LOG2.
  - in_ready = 1 after reset deasserts, unless clear is high.
- Latency: sample accepted at edge E → out_valid=1 with its result after edge E+2.
- Maximum throughput is one sample per 3 cycles when out_ready is held high. in_ready is 0 in FETCH and UPDATE.
- Backpressure: while out_valid=1 and out_ready=0, out_data is stable and in_ready=0.
- window_full = (fill == N). It goes high after the UPDATE edge of the Nth sample, together with that sample's out_valid.

## Test plan
- Reset, defaults (k=3, unsigned, truncate), out_ready=1. Feed eight samples of 16 → outputs 2,4,6,8,10,12,14,16. window_full rises with the 16 output.
- Continue from that state and feed eight 0s → outputs 14,12,10,8,6,4,2,0. window_full stays 1. Each output appears exactly 2 cycles after the accept edge.
- Hold out_ready=0 after the first result → out_data and out_valid stay stable and in_ready=0. A pending in_valid is not accepted. Raise out_ready for one cycle → handshake completes and the next sample is accepted on the following IDLE edge.
- Assert clear with win_log2=2 while in FETCH → no out_valid for the in-flight sample, and win_active=2. Then feed four samples of 255 → outputs 63,127,191,255.
- SIGNED=1, ROUND=1, clear with win_log2=1. Feed −3, then −4 → outputs −1 (0xFF), then −3 (0xFD).
- MAX_LOG2=4, k=4. Feed the ramp 0..39, which wraps the pointer twice → the output after sample 39 is 31 (sum of 24..39 = 504, 504>>4). The output after sample 15 is 7.
